// File: rtl/sdram_to_fx2_if.sv
// -----------------------------------------------------------------------------
// sdram_to_fx2_if
//   Bundles the two external buses of sdram_to_fx2:
//     * pipelined Wishbone read master towards SDRAM
//       (stb_i, cyc_i, we_i, sel_i, addr_i, data_i out; data_o, stall_o,
//        sdram_ack in -- names follow the SDRAM controller's point of view)
//     * FX2 EP6 IN synchronous slave-FIFO write side
//       (SLWR, SLRD, SLOE, IFCLK, FIFOADR, PKTEND, FDATA_out, FDATA_oe out;
//        FLAGB in, active-low full)
//   modport master : the sdram_to_fx2 bridge
//   modport slave  : the SDRAM controller / FX2 side (or a testbench)
// -----------------------------------------------------------------------------
interface sdram_to_fx2_if #(
  parameter int ADDR_W = 32
);
  // Wishbone pipelined read port
  logic              stb_i;
  logic              cyc_i;
  logic              we_i;
  logic [3:0]        sel_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       data_i;
  logic [31:0]       data_o;
  logic              stall_o;
  logic              sdram_ack;

  // FX2 slave-FIFO port
  logic              FLAGB;
  logic              SLWR;
  logic              SLRD;
  logic              SLOE;
  logic              IFCLK;
  logic [1:0]        FIFOADR;
  logic              PKTEND;
  logic [15:0]       FDATA_out;
  logic              FDATA_oe;

  modport master (
    output stb_i, cyc_i, we_i, sel_i, addr_i, data_i,
    input  data_o, stall_o, sdram_ack,
    input  FLAGB,
    output SLWR, SLRD, SLOE, IFCLK, FIFOADR, PKTEND, FDATA_out, FDATA_oe
  );

  modport slave (
    input  stb_i, cyc_i, we_i, sel_i, addr_i, data_i,
    output data_o, stall_o, sdram_ack,
    output FLAGB,
    input  SLWR, SLRD, SLOE, IFCLK, FIFOADR, PKTEND, FDATA_out, FDATA_oe
  );
endinterface

// File: rtl/sdram_to_fx2.sv
// -----------------------------------------------------------------------------
// sdram_to_fx2
//   Return path SDRAM -> host. A start pulse (accepted only when idle) launches
//   a burst read of len 32-bit words from base_addr over a pipelined Wishbone
//   master. Read data lands in a DEPTH-word FIFO and is streamed into the FX2
//   EP6 IN slave FIFO as two 16-bit halves per word, low half first.
//
//   Ports
//     CLKOUT     system clock, forwarded to the FX2 as IFCLK
//     rst        synchronous active-high reset
//     start      1-cycle start pulse, base_addr / len sampled with it
//     busy       high from accepted start until done
//     done       1-cycle pulse once the last half-word has been written
//     bus        sdram_to_fx2_if.master (Wishbone + FX2 slave FIFO)
//
//   Build option
//     FX2_PKTEND_EN  when defined, a PKTEND strobe (one cycle, only while the
//                    FX2 is not full) follows the last half-word so a short
//                    packet is committed to the host. Otherwise PKTEND is
//                    tied high and the transfer ends right after draining.
// -----------------------------------------------------------------------------
module sdram_to_fx2 #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              CLKOUT,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  sdram_to_fx2_if.master    bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [CNT_W-1:0] cnt_t;

`ifdef FX2_PKTEND_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_DRAIN, S_PKT, S_DONE} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_DRAIN, S_DONE} state_e;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  req_cnt_q, req_cnt_d;
  cnt_t              outst_q, outst_d;
  cnt_t              fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              half_q, half_d;
  logic              slwr_q, slwr_d;
  logic [15:0]       fdata_q, fdata_d;
  logic [31:0]       mem_q [DEPTH];

  logic [CNT_W:0]    occupancy;
  logic              stb_c;
  logic              cyc_c;
  logic              accept;
  logic              last_req;
  logic              ack_ok;
  logic              issue;
  logic              pop;
  logic [31:0]       head;

  // Every outstanding read owns a FIFO slot, so issuing only while
  // buffered + in-flight words < DEPTH makes overflow impossible.
  assign occupancy = {1'b0, fifo_cnt_q} + {1'b0, outst_q};
  assign stb_c     = (state_q == S_REQ) && (req_cnt_q != len_q)
                  && (occupancy < (CNT_W+1)'(DEPTH));
  assign cyc_c     = (state_q == S_REQ) || ((state_q == S_DRAIN) && (outst_q != '0));
  assign accept    = stb_c && !bus.stall_o;
  assign last_req  = (req_cnt_q + LEN_W'(1)) == len_q;

  // Acks with nothing outstanding belong to a transfer killed by reset.
  assign ack_ok    = bus.sdram_ack && (outst_q != '0);

  // A half-word is committed one cycle ahead of its SLWR strobe; the decision
  // uses FLAGB of the current cycle and the strobe/data are both registered.
  assign head      = mem_q[rd_ptr_q];
  assign issue     = (fifo_cnt_q != '0) && bus.FLAGB;
  assign pop       = issue && half_q;

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (len != '0) ? S_REQ : S_DONE;
      S_REQ:   if (accept && last_req) state_d = S_DRAIN;
`ifdef FX2_PKTEND_EN
      S_DRAIN: if ((outst_q == '0) && (fifo_cnt_q == '0)) state_d = S_PKT;
      S_PKT:   if (bus.FLAGB) state_d = S_DONE;
`else
      S_DRAIN: if ((outst_q == '0) && (fifo_cnt_q == '0)) state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next state: request counters, credit, FIFO pointers, FX2 output
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_d     = addr_q;
    len_d      = len_q;
    req_cnt_d  = req_cnt_q;
    outst_d    = outst_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    half_d     = half_q;
    slwr_d     = 1'b1;
    fdata_d    = fdata_q;

    if ((state_q == S_IDLE) && start) begin
      addr_d    = base_addr;
      len_d     = len;
      req_cnt_d = '0;
    end

    if (accept) begin
      addr_d    = addr_q + ADDR_W'(1);
      req_cnt_d = req_cnt_q + LEN_W'(1);
    end

    unique case ({accept, ack_ok})
      2'b10:   outst_d = outst_q + cnt_t'(1);
      2'b01:   outst_d = outst_q - cnt_t'(1);
      default: outst_d = outst_q;
    endcase

    if (ack_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({ack_ok, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + cnt_t'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - cnt_t'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    // While the FX2 is full nothing advances: FDATA and the half pointer
    // hold, so the same half is re-presented when FLAGB returns high.
    if (issue) begin
      slwr_d  = 1'b0;
      fdata_d = half_q ? head[31:16] : head[15:0];
      half_d  = ~half_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLKOUT) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers see the pre-edge values of each other.
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      req_cnt_q  <= '0;
      outst_q    <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      half_q     <= 1'b0;
      slwr_q     <= 1'b1;
      fdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      req_cnt_q  <= req_cnt_d;
      outst_q    <= outst_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      half_q     <= half_d;
      slwr_q     <= slwr_d;
      fdata_q    <= fdata_d;
    end
  end

  // NOTE: the FIFO storage has no reset; the empty count guards every read,
  // so stale contents are never observed and the array can map to RAM.
  always_ff @(posedge CLKOUT) begin
    if (ack_ok) mem_q[wr_ptr_q] <= bus.data_o;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
`ifdef FX2_PKTEND_EN
  assign busy       = (state_q == S_REQ) || (state_q == S_DRAIN) || (state_q == S_PKT);
  assign bus.PKTEND = !((state_q == S_PKT) && bus.FLAGB);
`else
  assign busy       = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign bus.PKTEND = 1'b1;
`endif
  assign done          = (state_q == S_DONE);

  assign bus.stb_i     = stb_c;
  assign bus.cyc_i     = cyc_c;
  assign bus.we_i      = 1'b0;
  assign bus.sel_i     = 4'hF;
  assign bus.addr_i    = addr_q;
  assign bus.data_i    = '0;

  assign bus.SLWR      = slwr_q;
  assign bus.SLRD      = 1'b1;
  assign bus.SLOE      = 1'b1;
  assign bus.IFCLK     = CLKOUT;
  assign bus.FIFOADR   = 2'b10;
  assign bus.FDATA_out = fdata_q;
  assign bus.FDATA_oe  = busy;

endmodule

// File: tb/tb_sdram_to_fx2.sv
// -----------------------------------------------------------------------------
// tb_sdram_to_fx2
//   Scoreboard bench for sdram_to_fx2. Starting a transfer pushes the expected
//   Wishbone addresses and FX2 half-words (derived from a reference memory
//   function) into queues; a monitor pops and compares whenever the DUT
//   accepts a read, strobes SLWR, strobes PKTEND or pulses done. A driver
//   process models the SDRAM (in-order acks, random latency and stall) and
//   the FX2 full flag.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdram_to_fx2;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;
`ifdef FX2_PKTEND_EN
  localparam int PKT_EXP = 1;
`else
  localparam int PKT_EXP = 0;
`endif

  logic              CLKOUT = 1'b0;
  logic              rst    = 1'b1;
  logic              start  = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  len       = '0;
  logic              busy;
  logic              done;

  sdram_to_fx2_if #(.ADDR_W(ADDR_W)) bus ();

  sdram_to_fx2 #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .CLKOUT    (CLKOUT),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 CLKOUT = ~CLKOUT;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference SDRAM contents: any address maps to a scrambled word.
  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = (a * 32'h9E37_79B1) ^ {a[15:0], ~a[15:0]};
    return w;
  endfunction

  logic [ADDR_W-1:0] exp_addr[$];
  logic [15:0]       exp_half[$];

  typedef struct {
    logic [ADDR_W-1:0] a;
    int                due;
  } pend_t;
  pend_t pend[$];

  // stimulus knobs
  int stall_mode = 0;   // 0 never, 1 every other cycle, 2 random
  int flagb_mode = 0;   // 0 never full, 1 random, 2 one 10-cycle window after 2nd write
  int lat_min    = 2;
  int lat_max    = 2;
  int flagb_low_left = 0;
  bit flagb_trig = 1'b0;
  int cyc_n      = 0;
  int last_due   = 0;

  // per-run scoreboard state
  bit run_active = 1'b0;
  int run_len    = 0;
  int run_acc    = 0;
  int run_ack    = 0;
  int run_wr     = 0;
  int run_pkt    = 0;
  int run_done   = 0;
  int first_ack_cyc = -1;
  int first_wr_cyc  = -1;
  int done_cyc   = 0;
  int start_cyc  = 0;

  // ---------------------------------------------------------------------------
  // SDRAM + FX2 flag driver: samples requests at negedge, drives at posedge+1
  // ---------------------------------------------------------------------------
  initial begin : driver
    logic              acc;
    logic [ADDR_W-1:0] acc_a;
    int                lat;
    int                due;
    pend_t             p;
    bus.stall_o   = 1'b0;
    bus.sdram_ack = 1'b0;
    bus.data_o    = '0;
    bus.FLAGB     = 1'b1;
    forever begin
      @(negedge CLKOUT);
      acc   = bus.stb_i && bus.cyc_i && !bus.stall_o && !rst;
      acc_a = bus.addr_i;
      @(posedge CLKOUT);
      cyc_n++;
      #1;
      if (acc) begin
        lat = int'($urandom_range(lat_max, lat_min));
        due = cyc_n + lat - 1;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{acc_a, due});
      end
      if (pend.size() > 0 && pend[0].due <= cyc_n) begin
        p = pend.pop_front();
        bus.sdram_ack = 1'b1;
        bus.data_o    = mem_word(p.a);
      end else begin
        bus.sdram_ack = 1'b0;
        bus.data_o    = $urandom;
      end
      case (stall_mode)
        1:       bus.stall_o = cyc_n[0];
        2:       bus.stall_o = ($urandom_range(2, 0) == 0);
        default: bus.stall_o = 1'b0;
      endcase
      case (flagb_mode)
        1: bus.FLAGB = ($urandom_range(3, 0) != 0);
        2: begin
          if (flagb_low_left > 0) begin
            bus.FLAGB = 1'b0;
            flagb_low_left--;
          end else if (!flagb_trig && run_wr == 2) begin
            bus.FLAGB      = 1'b0;
            flagb_trig     = 1'b1;
            flagb_low_left = 9;
          end else begin
            bus.FLAGB = 1'b1;
          end
        end
        default: bus.FLAGB = 1'b1;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: pops expectations whenever the DUT presents an event
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic        flagb_prev;
    logic        busy_prev;
    logic [15:0] fdata_prev;
    flagb_prev = 1'b1;
    busy_prev  = 1'b0;
    fdata_prev = '0;
    forever begin
      @(negedge CLKOUT);
      if (!rst && run_active) begin
        if (bus.stb_i && bus.cyc_i && !bus.stall_o) begin
          run_acc++;
          if (exp_addr.size() == 0) check("unexpected_read", 1, 0);
          else check("read_addr", bus.addr_i, exp_addr.pop_front());
          check("outstanding_le_depth", 64'((run_acc - run_ack) <= DEPTH), 1);
        end
        if (bus.sdram_ack) begin
          run_ack++;
          if (first_ack_cyc < 0) first_ack_cyc = cyc_n;
        end
        if (!bus.SLWR) begin
          run_wr++;
          check("slwr_only_when_not_full", flagb_prev, 1);
          if (exp_half.size() == 0) check("unexpected_write", 1, 0);
          else check("fdata", bus.FDATA_out, exp_half.pop_front());
          if (first_wr_cyc < 0) begin
            first_wr_cyc = cyc_n;
            check("first_slwr_ge_2_after_ack",
                  64'(first_ack_cyc >= 0 && (first_wr_cyc - first_ack_cyc) >= 2), 1);
          end
        end else if (!flagb_prev && busy) begin
          check("fdata_held_while_full", bus.FDATA_out, fdata_prev);
        end
        if (!bus.PKTEND) begin
          run_pkt++;
          check("pktend_after_last_write", run_wr, 2 * run_len);
          check("pktend_not_full", bus.FLAGB, 1);
          check("pktend_before_done", done, 0);
        end
        if (done) begin
          run_done++;
          done_cyc = cyc_n;
          check("busy_low_at_done", busy, 0);
          check("busy_before_done", busy_prev, (run_len != 0));
          check("all_reads_issued", run_acc, run_len);
          check("all_halves_written", run_wr, 2 * run_len);
          check("addr_queue_empty", exp_addr.size(), 0);
          check("pktend_count", run_pkt, (run_len != 0) ? PKT_EXP : 0);
        end
      end
      flagb_prev = bus.FLAGB;
      busy_prev  = busy;
      fdata_prev = bus.FDATA_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence helpers
  // ---------------------------------------------------------------------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    busy,          0);
    check({tag, "_done"},    done,          0);
    check({tag, "_slwr"},    bus.SLWR,      1);
    check({tag, "_pktend"},  bus.PKTEND,    1);
    check({tag, "_stb"},     bus.stb_i,     0);
    check({tag, "_cyc"},     bus.cyc_i,     0);
    check({tag, "_addr"},    bus.addr_i,    0);
    check({tag, "_fdata"},   bus.FDATA_out, 0);
    check({tag, "_fdataoe"}, bus.FDATA_oe,  0);
    check({tag, "_fifoadr"}, bus.FIFOADR,   2'b10);
    check({tag, "_ctl"},     {bus.SLRD, bus.SLOE, bus.we_i, bus.sel_i}, 7'b110_1111);
  endtask

  task automatic pulse_reset();
    @(posedge CLKOUT); #1;
    rst        = 1'b1;
    run_active = 1'b0;
    exp_addr.delete();
    exp_half.delete();
    @(posedge CLKOUT); #1;
    rst = 1'b0;
  endtask

  task automatic start_run(input logic [ADDR_W-1:0] b, input int l);
    logic [31:0] w;
    @(posedge CLKOUT); #1;
    run_len = l; run_acc = 0; run_ack = 0; run_wr = 0; run_pkt = 0; run_done = 0;
    first_ack_cyc = -1; first_wr_cyc = -1;
    for (int i = 0; i < l; i++) begin
      exp_addr.push_back(b + ADDR_W'(i));
      w = mem_word(b + ADDR_W'(i));
      exp_half.push_back(w[15:0]);
      exp_half.push_back(w[31:16]);
    end
    run_active = 1'b1;
    start      = 1'b1;
    base_addr  = b;
    len        = LEN_W'(l);
    start_cyc  = cyc_n;
    @(posedge CLKOUT); #1;
    start = 1'b0;
  endtask

  task automatic run_transfer(input logic [ADDR_W-1:0] b, input int l, input bit poke);
    int budget;
    start_run(b, l);
    if (poke) begin
      repeat (3) @(posedge CLKOUT);
      #1;
      if (busy) begin
        start = 1'b1; base_addr = 32'hDEAD_0000; len = LEN_W'(5);
        @(posedge CLKOUT); #1;
        start = 1'b0;
      end
    end
    budget = 0;
    while (run_done == 0 && budget < 60 * l + 100) begin
      @(posedge CLKOUT);
      budget++;
    end
    if (run_done == 0) begin
      check("done_timeout", 0, 1);
      pulse_reset();
      repeat (10) @(posedge CLKOUT);
    end else begin
      if (l == 0) check("len0_done_latency", done_cyc - start_cyc, 1);
      repeat (3) @(posedge CLKOUT);
      check("single_done_pulse", run_done, 1);
      run_active = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    int wait_cnt;
    repeat (3) @(posedge CLKOUT);
    #1 rst = 1'b0;
    @(negedge CLKOUT);
    check_reset_outputs("por");

    // basic burst, fixed 2-cycle ack latency
    stall_mode = 0; flagb_mode = 0; lat_min = 2; lat_max = 2;
    run_transfer(32'h100, 4, 1'b0);

    // stall toggling, longer than the buffer
    stall_mode = 1; lat_min = 1; lat_max = 3;
    run_transfer(32'h4000, 20, 1'b0);

    // FX2 full for 10 cycles in the middle of a word
    stall_mode = 0; lat_min = 2; lat_max = 2; flagb_mode = 2; flagb_trig = 1'b0;
    run_transfer(32'h800, 6, 1'b0);
    flagb_mode = 0;

    // zero-length transfer
    run_transfer(32'h55, 0, 1'b0);

    // reset in the middle of a transfer, stray acks afterwards
    lat_min = 3; lat_max = 3;
    start_run(32'h2000, 16);
    wait_cnt = 0;
    while (run_ack < 3 && wait_cnt < 200) begin
      @(negedge CLKOUT);
      wait_cnt++;
    end
    check("mid_reset_reached_3_acks", 64'(run_ack >= 3), 1);
    pulse_reset();
    @(negedge CLKOUT);
    check_reset_outputs("midrst");
    repeat (10) @(posedge CLKOUT);
    lat_min = 1; lat_max = 3;
    run_transfer(32'h2100, 2, 1'b0);

    // short packet (PKTEND when enabled)
    run_transfer(32'h3000, 3, 1'b0);

    // randomized runs, one with a start pulse while busy
    for (int k = 0; k < 5; k++) begin
      stall_mode = 2; flagb_mode = 1; lat_min = 1; lat_max = 3;
      run_transfer($urandom, (k == 1) ? 16 : int'($urandom_range(24, 1)), k == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #(800_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
